// File: rtl/ad9361_ctrl_pkg.sv
// Shared definitions for the dual AD9361 capture controller.
//   state_t            : capture sequencer states (2-bit)
//   DEF_CNT_WIDTH      : default width of burst-length / sample counters
//   DEF_SETTLE_CYCLES  : default ENABLE settle interval in clk cycles
//   DEF_SKEW_MAX       : default allowed A-to-B beat skew in clk cycles
package ad9361_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_WAIT_TRIG = 2'd2,
        ST_CAPTURE   = 2'd3
    } state_t;

    localparam int DEF_CNT_WIDTH     = 24;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_SKEW_MAX      = 4;

endpackage

// File: rtl/ad9361_skew_mon.sv
// A/B beat alignment monitor for the dual AD9361 receive path.
//   clk, reset : core clock, synchronous active-high reset
//   clear      : clears pending state and the sticky error (accepted start)
//   active     : monitor enabled (capture in progress); pending state drops when low
//   valid_a/b  : chip-A / chip-B sample beats
//   skew_err   : sticky misalignment flag
module ad9361_skew_mon
    import ad9361_ctrl_pkg::*;
#(
    parameter int SKEW_MAX = DEF_SKEW_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic valid_a,
    input  logic valid_b,
    output logic skew_err
);

    localparam int TW = $clog2(SKEW_MAX + 2);

    logic          pend_a;
    logic          pend_b;
    logic [TW-1:0] timer;
    logic          only_a;
    logic          only_b;

    // Simultaneous A and B beats pair with each other and leave pending state alone.
    assign only_a = valid_a & ~valid_b;
    assign only_b = valid_b & ~valid_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            timer    <= '0;
            skew_err <= 1'b0;
        end else if (clear) begin
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            timer    <= '0;
            skew_err <= 1'b0;
        end else if (!active) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            timer  <= '0;
        end else if (pend_a | pend_b) begin
            if ((pend_a & only_b) | (pend_b & only_a)) begin
                pend_a <= 1'b0;
                pend_b <= 1'b0;
                timer  <= '0;
            end else begin
                if ((pend_a & only_a) | (pend_b & only_b))
                    skew_err <= 1'b1;
                // timer holds the age of the pending beat; at SKEW_MAX with no
                // match this cycle the next cycle exceeds the limit
                if (timer >= TW'(SKEW_MAX))
                    skew_err <= 1'b1;
                else
                    timer <= timer + TW'(1);
            end
        end else if (only_a) begin
            pend_a <= 1'b1;
            timer  <= TW'(1);
        end else if (only_b) begin
            pend_b <= 1'b1;
            timer  <= TW'(1);
        end
    end

endmodule

// File: rtl/ad9361_capture_ctrl.sv
// Capture sequencer for the dual AD9361 receive path.
//   cfg_start/abort     : start / abort pulses
//   cfg_continuous      : re-arm the burst counter after each burst
//   cfg_trig_en         : wait for a trigger rising edge after settle
//   cfg_num_samples     : burst length in chip-A beats (latched on start)
//   trigger             : external level trigger
//   valid_a/b           : chip-A / chip-B beats
//   enable_a/b, txnrx   : AD9361 control pins
//   gate, last          : serializer qualifier and tlast source
//   busy, done          : activity status and burst-complete pulse
//   skew_err            : sticky A/B misalignment flag
//   samp_count          : beats captured in the current burst
module ad9361_capture_ctrl
    import ad9361_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SKEW_MAX      = DEF_SKEW_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic                 cfg_continuous,
    input  logic                 cfg_trig_en,
    input  logic [CNT_WIDTH-1:0] cfg_num_samples,
    input  logic                 trigger,
    input  logic                 valid_a,
    input  logic                 valid_b,
    output logic                 enable_a,
    output logic                 enable_b,
    output logic                 txnrx,
    output logic                 gate,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic                 skew_err,
    output logic [CNT_WIDTH-1:0] samp_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] num_lat;
    logic                 cont_lat;
    logic                 trig_en_lat;
    logic [SW-1:0]        settle_cnt;
    logic                 trig_q;
    logic                 enable_r;
    logic                 done_r;
    logic                 start_ok;
    logic                 trig_rise;
    logic                 beat;
    logic                 last_beat;

    assign start_ok  = (state == ST_IDLE) & cfg_start & ~cfg_abort;
    assign trig_rise = trigger & ~trig_q;
    // Reset also drops the qualifier so a reset landing on the final beat emits no last.
    assign gate      = (state == ST_CAPTURE) & ~cfg_abort & ~reset;
    assign beat      = gate & valid_a;
    assign last_beat = beat & (samp_count == num_lat - CNT_WIDTH'(1));

    assign last     = last_beat;
    assign busy     = (state != ST_IDLE);
    assign done     = done_r;
    assign enable_a = enable_r;
    assign enable_b = enable_r;
    assign txnrx    = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (start_ok && (cfg_num_samples != '0))
                    state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (settle_cnt == SW'(SETTLE_CYCLES - 1))
                    state_nxt = trig_en_lat ? ST_WAIT_TRIG : ST_CAPTURE;
            ST_WAIT_TRIG:
                if (trig_rise)
                    state_nxt = ST_CAPTURE;
            ST_CAPTURE:
                if (last_beat && !cont_lat)
                    state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
        if (cfg_abort)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            num_lat     <= '0;
            cont_lat    <= 1'b0;
            trig_en_lat <= 1'b0;
            settle_cnt  <= '0;
            trig_q      <= 1'b0;
            enable_r    <= 1'b0;
            done_r      <= 1'b0;
            samp_count  <= '0;
        end else begin
            state    <= state_nxt;
            trig_q   <= trigger;
            // Registered from the next state so the pins rise on the first SETTLE
            // cycle and fall on the first IDLE cycle.
            enable_r <= (state_nxt != ST_IDLE);
            done_r   <= 1'b0;

            if (state == ST_SETTLE)
                settle_cnt <= settle_cnt + SW'(1);
            else
                settle_cnt <= '0;

            if (start_ok) begin
                num_lat     <= cfg_num_samples;
                cont_lat    <= cfg_continuous;
                trig_en_lat <= cfg_trig_en;
                samp_count  <= '0;
                if (cfg_num_samples == '0)
                    done_r <= 1'b1;
            end else if (beat) begin
                if (last_beat && cont_lat) begin
                    samp_count <= '0;
                end else begin
                    samp_count <= samp_count + CNT_WIDTH'(1);
                    if (last_beat)
                        done_r <= 1'b1;
                end
            end
        end
    end

    ad9361_skew_mon #(
        .SKEW_MAX(SKEW_MAX)
    ) u_skew_mon (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok),
        .active  (state == ST_CAPTURE),
        .valid_a (valid_a),
        .valid_b (valid_b),
        .skew_err(skew_err)
    );

endmodule

// File: tb/tb_ad9361_capture_ctrl.sv
module tb_ad9361_capture_ctrl;

    localparam int CW       = 24;
    localparam int SETTLE   = 64;
    localparam int SKEW_MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          cfg_abort;
    logic          cfg_continuous;
    logic          cfg_trig_en;
    logic [CW-1:0] cfg_num_samples;
    logic          trigger;
    logic          valid_a;
    logic          valid_b;
    logic          enable_a;
    logic          enable_b;
    logic          txnrx;
    logic          gate;
    logic          last;
    logic          busy;
    logic          done;
    logic          skew_err;
    logic [CW-1:0] samp_count;

    int checks = 0;
    int errors = 0;

    ad9361_capture_ctrl #(
        .CNT_WIDTH    (CW),
        .SETTLE_CYCLES(SETTLE),
        .SKEW_MAX     (SKEW_MAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_continuous (cfg_continuous),
        .cfg_trig_en    (cfg_trig_en),
        .cfg_num_samples(cfg_num_samples),
        .trigger        (trigger),
        .valid_a        (valid_a),
        .valid_b        (valid_b),
        .enable_a       (enable_a),
        .enable_b       (enable_b),
        .txnrx          (txnrx),
        .gate           (gate),
        .last           (last),
        .busy           (busy),
        .done           (done),
        .skew_err       (skew_err),
        .samp_count     (samp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the sequence in terms of "how many settle cycles remain",
    // "waiting for a trigger", "capturing", and keeps unmatched beat
    // timestamps per chip in queues to judge skew by age.
    bit mdl_live = 0;
    bit m_busy = 0, m_wait = 0, m_capt = 0, m_cont = 0, m_trig_en = 0;
    bit m_done = 0, m_skew = 0, prev_trig = 0;
    int settle_left = 0, m_n = 0, m_count = 0, cyc = 0;
    int qa[$];
    int qb[$];

    always @(negedge clk) begin
        bit exp_gate, exp_last, nd, oa, ob;
        exp_gate = m_capt && !cfg_abort && !reset;
        exp_last = exp_gate && valid_a && (m_count == m_n - 1);
        if (mdl_live) begin
            chk("busy",       32'(busy),       32'(m_busy));
            chk("enable_a",   32'(enable_a),   32'(m_busy));
            chk("enable_b",   32'(enable_b),   32'(m_busy));
            chk("txnrx",      32'(txnrx),      0);
            chk("gate",       32'(gate),       32'(exp_gate));
            chk("last",       32'(last),       32'(exp_last));
            chk("done",       32'(done),       32'(m_done));
            chk("skew_err",   32'(skew_err),   32'(m_skew));
            chk("samp_count", 32'(samp_count), m_count);
        end
        if (reset) begin
            m_busy = 0; m_wait = 0; m_capt = 0; settle_left = 0;
            m_count = 0; m_done = 0; m_skew = 0; prev_trig = 0;
            qa.delete(); qb.delete();
            mdl_live = 1;
        end else begin
            nd = 0;
            if (m_capt) begin
                oa = valid_a && !valid_b;
                ob = valid_b && !valid_a;
                if (oa) begin
                    if (qb.size() > 0) void'(qb.pop_front());
                    else if (qa.size() > 0) m_skew = 1;
                    else qa.push_back(cyc);
                end
                if (ob) begin
                    if (qa.size() > 0) void'(qa.pop_front());
                    else if (qb.size() > 0) m_skew = 1;
                    else qb.push_back(cyc);
                end
                if (qa.size() > 0 && cyc > qa[0] && cyc - qa[0] >= SKEW_MAX) m_skew = 1;
                if (qb.size() > 0 && cyc > qb[0] && cyc - qb[0] >= SKEW_MAX) m_skew = 1;
            end else begin
                qa.delete(); qb.delete();
            end
            if (!m_busy) begin
                if (cfg_start && !cfg_abort) begin
                    m_n = int'(cfg_num_samples); m_cont = cfg_continuous;
                    m_trig_en = cfg_trig_en; m_count = 0; m_skew = 0;
                    qa.delete(); qb.delete();
                    if (m_n == 0) nd = 1;
                    else begin m_busy = 1; settle_left = SETTLE; end
                end
            end else if (cfg_abort) begin
                m_busy = 0; m_wait = 0; m_capt = 0; settle_left = 0;
            end else if (settle_left > 0) begin
                settle_left--;
                if (settle_left == 0) begin
                    if (m_trig_en) m_wait = 1; else m_capt = 1;
                end
            end else if (m_wait) begin
                if (trigger && !prev_trig) begin m_wait = 0; m_capt = 1; end
            end else if (m_capt && valid_a) begin
                if (m_count == m_n - 1) begin
                    if (m_cont) m_count = 0;
                    else begin m_count++; nd = 1; m_busy = 0; m_capt = 0; end
                end else m_count++;
            end
            m_done = nd;
            prev_trig = trigger;
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has already peeked the current cycle; returns peeked at the gate cycle.
    task automatic wait_gate(input string nm, output int k);
        k = 0;
        while (!gate && k < 300) begin tick(); #1; k++; end
        if (!gate) chk(nm, 32'(gate), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, beats, lasts, last_idx, done_seen;
        int last_mask;
        reset = 1; cfg_start = 0; cfg_abort = 0; cfg_continuous = 0; cfg_trig_en = 0;
        cfg_num_samples = '0; trigger = 0; valid_a = 0; valid_b = 0;
        tick(); tick(); #1;
        chk("reset_busy",  32'(busy), 0);
        chk("reset_en",    32'(enable_a), 0);
        chk("reset_count", 32'(samp_count), 0);
        tick(); reset = 0;

        // T1: N=8, no trigger, beats every 3rd cycle
        cfg_num_samples = 8; cfg_start = 1;
        tick(); cfg_start = 0; #1;
        chk("t1_enable_first_settle", 32'(enable_a), 1);
        wait_gate("t1_gate_timeout", k);
        chk("t1_settle_len", k, 64);
        beats = 0; lasts = 0; last_idx = 0;
        for (int i = 0; i < 40 && beats < 8; i++) begin
            valid_a = (i % 3 == 0); valid_b = valid_a; #1;
            if (gate && valid_a) begin
                beats++;
                if (last) begin lasts++; last_idx = beats; end
            end
            tick();
        end
        valid_a = 0; valid_b = 0; #1;
        chk("t1_beats", beats, 8);
        chk("t1_last_count", lasts, 1);
        chk("t1_last_on_8th", last_idx, 8);
        chk("t1_done_pulse", 32'(done), 1);
        chk("t1_enable_low", 32'(enable_a), 0);
        tick(); #1;
        chk("t1_done_one_cycle", 32'(done), 0);

        // T2: trigger high before start, then low, then high
        trigger = 1; cfg_num_samples = 5; cfg_trig_en = 1; cfg_start = 1;
        tick(); cfg_start = 0;
        repeat (70) tick();
        #1;
        chk("t2_no_fire_on_level", 32'(gate), 0);
        chk("t2_still_busy", 32'(busy), 1);
        tick(); trigger = 0; tick(); tick(); trigger = 1; #1;
        chk("t2_rise_cycle_no_gate", 32'(gate), 0);
        tick(); #1;
        chk("t2_capture_after_rise", 32'(gate), 1);
        tick(); cfg_abort = 1; valid_a = 1; #1;
        chk("t2_abort_gate", 32'(gate), 0);
        tick(); cfg_abort = 0; valid_a = 0; trigger = 0; cfg_trig_en = 0; #1;
        chk("t2_abort_idle", 32'(busy), 0);
        chk("t2_abort_no_done", 32'(done), 0);

        // T3: continuous N=4, 12 beats, then abort
        tick(); cfg_continuous = 1; cfg_num_samples = 4; cfg_start = 1;
        tick(); cfg_start = 0; #1;
        wait_gate("t3_gate_timeout", k);
        beats = 0; last_mask = 0; done_seen = 0;
        for (int i = 0; i < 60 && beats < 12; i++) begin
            valid_a = (i % 2 == 0); valid_b = valid_a; #1;
            if (done) done_seen++;
            if (gate && valid_a) begin
                beats++;
                if (last) last_mask |= (1 << beats);
            end
            tick();
        end
        valid_a = 0; valid_b = 0; #1;
        chk("t3_last_positions", last_mask, 32'h0000_1110);
        chk("t3_wrapped", 32'(samp_count), 0);
        chk("t3_no_done", done_seen + 32'(done), 0);
        cfg_abort = 1; valid_a = 1; #1;
        chk("t3_abort_gate", 32'(gate), 0);
        chk("t3_abort_last", 32'(last), 0);
        tick(); cfg_abort = 0; valid_a = 0; cfg_continuous = 0; #1;
        chk("t3_idle", 32'(busy), 0);
        chk("t3_abort_no_done", 32'(done), 0);

        // T4: N=0 start
        cfg_num_samples = 0; cfg_start = 1; #1;
        tick(); cfg_start = 0; #1;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_enable", 32'(enable_a), 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); #1; done_seen += 32'(done) + 32'(busy); end
        chk("t4_single_pulse", done_seen, 0);

        // T5: skew lag 5 -> error, then lag 4 after a new start -> none
        cfg_num_samples = 20; cfg_start = 1;
        tick(); cfg_start = 0; #1;
        wait_gate("t5_gate_timeout", k);
        valid_a = 1; tick(); valid_a = 0;
        for (int j = 1; j <= 5; j++) begin
            valid_b = (j == 5); #1;
            if (j == 4) chk("t5_no_err_at_4", 32'(skew_err), 0);
            if (j == 5) chk("t5_err_at_5", 32'(skew_err), 1);
            tick();
        end
        valid_b = 0; cfg_abort = 1;
        tick(); cfg_abort = 0; #1;
        chk("t5_sticky", 32'(skew_err), 1);
        tick(); cfg_start = 1;
        tick(); cfg_start = 0; #1;
        chk("t5_cleared_by_start", 32'(skew_err), 0);
        wait_gate("t5b_gate_timeout", k);
        valid_a = 1; tick(); valid_a = 0;
        for (int j = 1; j <= 8; j++) begin
            valid_b = (j == 4); #1;
            if (j == 8) chk("t5_lag4_ok", 32'(skew_err), 0);
            tick();
        end
        valid_b = 0; cfg_abort = 1;
        tick(); cfg_abort = 0;

        // T6: reset on the N-1 beat
        cfg_num_samples = 3; cfg_start = 1;
        tick(); cfg_start = 0; #1;
        wait_gate("t6_gate_timeout", k);
        valid_a = 1; valid_b = 1; tick(); tick();
        reset = 1; #1;
        chk("t6_count_at_n1", 32'(samp_count), 2);
        chk("t6_no_last", 32'(last), 0);
        tick(); reset = 0; valid_a = 0; valid_b = 0; #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_count", 32'(samp_count), 0);
        chk("t6_enable", 32'(enable_b), 0);
        tick(); #1;
        chk("t6_no_late_done", 32'(done), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9361_capture_ctrl.md
Name: ad9361_capture_ctrl

Overview:
Capture sequencer for the dual AD9361 receive path. It drives both chips' ENABLE and TXNRX pins and waits a settle interval. It can optionally wait for an external trigger, then gates a burst of N four-channel samples into the AXI-stream serializer and marks the final beat. It also monitors the beat skew between chip A and chip B and reports when the two chips fall out of alignment.

Parameters:
CNT_WIDTH, 24, width of the burst-length and sample counters
SETTLE_CYCLES, 64, clk cycles ENABLE is held before capture may begin (must be >= 1)
SKEW_MAX, 4, maximum clk cycles allowed between a chip-A beat and its matching chip-B beat

Ports:
clk  in  1  core clock (same domain as the cmos interface outputs)
reset  in  1  synchronous, active-high reset
cfg_start  in  1  single-cycle pulse; begins a capture when idle
cfg_abort  in  1  single-cycle pulse; terminates any activity
cfg_continuous  in  1  1 = re-arm the burst counter after each burst without leaving CAPTURE
cfg_trig_en  in  1  1 = wait for trigger after settle
cfg_num_samples  in  CNT_WIDTH  burst length in chip-A beats; sampled on accepted start
trigger  in  1  external trigger, level; rising edge is detected internally
valid_a  in  1  chip-A sample beat (valid_0 of interface A)
valid_b  in  1  chip-B sample beat (valid_0 of interface B)
enable_a  out  1  AD9361 A ENABLE pin
enable_b  out  1  AD9361 B ENABLE pin
txnrx  out  1  AD9361 TXNRX pins; constant 0 (receive only)
gate  out  1  qualifies valids into the serializer
last  out  1  final beat of a burst (tlast source)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after a burst completes
skew_err  out  1  sticky A/B misalignment flag
samp_count  out  CNT_WIDTH  beats captured in the current burst

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; the trigger edge register is loaded with 0.
- States: IDLE, SETTLE, WAIT_TRIG, CAPTURE.
- IDLE:
  - On cfg_start with cfg_abort=0: latch cfg_num_samples, cfg_continuous and cfg_trig_en; clear skew_err and samp_count; go to SETTLE.
  - If the latched length is 0: stay IDLE and pulse done on the next cycle.
- SETTLE:
  - enable_a and enable_b are registered 1 from the first SETTLE cycle.
  - Exactly SETTLE_CYCLES cycles are spent here.
  - Exit to WAIT_TRIG if trig_en, else to CAPTURE.
- WAIT_TRIG:
  - enable stays 1.
  - A trigger rising edge (trigger=1 with the previous-cycle register=0) moves to CAPTURE on the next cycle.
  - A trigger already high on entry does not fire.
- CAPTURE:
  - gate = (state==CAPTURE) & ~cfg_abort, combinational.
  - Each valid_a cycle increments samp_count.
  - last = gate & valid_a & (samp_count == N-1), combinational, same cycle as the beat.
  - On the last beat with continuous=0: go to IDLE; enables drop next cycle; done pulses one cycle after the last beat.
  - On the last beat with continuous=1: samp_count wraps to 0, state stays CAPTURE, no done pulse.
- Abort:
  - Any state goes to IDLE next cycle; enables drop; no done pulse; last is suppressed in the abort cycle.
  - Abort wins over start in the same cycle.
- cfg_start while busy is ignored; configuration changes while busy have no effect until the next start.
- Skew monitor (active only in CAPTURE):
  - valid_a and valid_b in the same cycle count as matched.
  - An unmatched beat on one side sets a pending flag with a cycle timer.
  - An opposite-side beat clears the pending flag.
  - If the timer exceeds SKEW_MAX, skew_err is set (sticky until the next accepted start or reset); capture continues.
  - A second same-side beat while pending sets skew_err immediately.
- A synchronous reset mid-capture returns to the reset values on the next edge; no last and no done are emitted.

Decomposition:
- Package ad9361_ctrl_pkg holds:
  - the state enum (2-bit)
  - default SETTLE_CYCLES and SKEW_MAX constants
  - the CNT_WIDTH default
- One sub-module, ad9361_skew_mon, holds the pending flags, the timer and the sticky error. Its ports are clk, reset, clear, active, valid_a, valid_b and skew_err.

Test Plan:
- start, N=8, trig_en=0, valid_a=valid_b every 3rd cycle -> enables high 64 cycles before the first gate; 8 gated beats; last on the 8th; done 1 cycle later; enables low.
- trig_en=1, trigger held high before start, then low, then high -> no capture on the pre-high level; CAPTURE begins the cycle after the rising edge.
- continuous=1, N=4, 12 beats, then abort -> last on beats 4, 8 and 12; samp_count wraps to 0; no done; gate low in the abort cycle.
- N=0 start -> busy stays 0; done pulses once; enables never assert.
- valid_b lags valid_a by 5 cycles with SKEW_MAX=4 -> skew_err set 5 cycles after the A beat; a lag of 4 -> no error; the next start clears it.
- reset asserted on the beat with samp_count=N-1 -> last and done never assert; all outputs 0 next cycle.
